// File: rtl/instr_encoder_if.sv
// Command/IMEM bus between a program source and the instruction encoder.
// The master drives symbolic commands; the slave (encoder) returns ready and IMEM writes.
interface instr_encoder_if #(
    parameter int ADDR_W = 6
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [1:0]        cmd_cond;
    logic              cmd_imm_sel;
    logic              cmd_s;
    logic [3:0]        cmd_rd;
    logic [3:0]        cmd_rn;
    logic [3:0]        cmd_rm;
    logic [23:0]       cmd_imm;
    logic              cmd_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output cmd_valid, cmd_op, cmd_cond, cmd_imm_sel, cmd_s,
               cmd_rd, cmd_rn, cmd_rm, cmd_imm, cmd_last,
        input  cmd_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_cond, cmd_imm_sel, cmd_s,
               cmd_rd, cmd_rn, cmd_rm, cmd_imm, cmd_last,
        output cmd_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder.sv
// Encodes symbolic ADD/SUB/CMP/MOV/LDR/STR/B/BL commands into ARM words and
// writes them sequentially into IMEM, one cycle after each accepted command.
module instr_encoder #(
    parameter int ADDR_W    = 6,
    parameter int DEPTH     = 64,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    instr_encoder_if.slave    bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic              accept;
    logic              cmd_bad;

    function automatic logic [3:0] cond_bits(input logic [1:0] cond);
        case (cond)
            2'd1:    return 4'b0000;
            2'd2:    return 4'b0001;
            default: return 4'b1110;
        endcase
    endfunction

    function automatic logic [31:0] encode(
        input logic [2:0]  op,
        input logic [1:0]  cond,
        input logic        imm_sel,
        input logic        s,
        input logic [3:0]  rd,
        input logic [3:0]  rn,
        input logic [3:0]  rm,
        input logic [23:0] imm
    );
        logic [3:0]  c;
        logic [3:0]  opc;
        logic [11:0] op2;
        c = cond_bits(cond);
        case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
                case (op)
                    3'd0:    opc = 4'b0100;
                    3'd1:    opc = 4'b0010;
                    3'd2:    opc = 4'b1010;
                    default: opc = 4'b1101;
                endcase
                op2 = imm_sel ? {4'h0, imm[7:0]} : {8'h0, rm};
                // CMP always sets flags and has no destination; MOV has no first operand
                return {c, 2'b00, imm_sel, opc, (op == 3'd2) ? 1'b1 : s,
                        (op == 3'd3) ? 4'h0 : rn,
                        (op == 3'd2) ? 4'h0 : rd, op2};
            end
            3'd4, 3'd5: begin
                op2 = imm_sel ? imm[11:0] : {8'h0, rm};
                return {c, 2'b01, ~imm_sel, 4'b1100, (op == 3'd5), rn, rd, op2};
            end
            default:
                return {c, 3'b101, (op == 3'd7), imm};
        endcase
    endfunction

    function automatic logic is_bad(
        input logic [2:0]      op,
        input logic [1:0]      cond,
        input logic            imm_sel,
        input logic [23:0]     imm,
        input logic [ADDR_W:0] cnt
    );
        logic bad;
        bad = (cond == 2'd3) || (cnt == DEPTH_C);
        if (imm_sel && op <= 3'd3 && (|imm[23:8]))
            bad = 1'b1;
        if (imm_sel && (op == 3'd4 || op == 3'd5) && (|imm[23:12]))
            bad = 1'b1;
        return bad;
    endfunction

    assign accept  = bus.cmd_valid && (state_q == S_LOAD);
    assign cmd_bad = is_bad(bus.cmd_op, bus.cmd_cond, bus.cmd_imm_sel,
                            bus.cmd_imm, count_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= BASE_C;
            wdata_q <= 32'h0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  if (accept && bus.cmd_last) state_d = S_FLUSH;
            S_FLUSH: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = (state_q == S_LOAD);
        busy          = (state_q != S_IDLE);
        done          = (state_q == S_DONE);
    end

    // Bad commands are consumed without a write; count saturates at DEPTH via the overflow error
    always_comb begin
        we_d    = accept && !cmd_bad;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        err_d   = err_q;
        if (state_q == S_IDLE && start) begin
            count_d = '0;
            err_d   = 1'b0;
        end
        if (accept && cmd_bad)
            err_d = 1'b1;
        if (we_d) begin
            addr_d  = BASE_C + count_q[ADDR_W-1:0];
            wdata_d = encode(bus.cmd_op, bus.cmd_cond, bus.cmd_imm_sel, bus.cmd_s,
                             bus.cmd_rd, bus.cmd_rn, bus.cmd_rm, bus.cmd_imm);
            count_d = count_q + 1'b1;
        end
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign err            = err_q;
    assign count          = count_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder with hand-encoded ARM words.
module tb_instr_encoder;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            busy;
    logic            done;
    logic            err;
    logic [ADDR_W:0] count;
    int              checks = 0;
    int              errors = 0;

    instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(0)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bus   (bus.slave),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .count (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [2:0] op, input logic [1:0] cond, input logic imm_sel,
                       input logic s, input logic [3:0] rd, input logic [3:0] rn,
                       input logic [3:0] rm, input logic [23:0] imm, input logic last);
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = op;
        bus.cmd_cond    = cond;
        bus.cmd_imm_sel = imm_sel;
        bus.cmd_s       = s;
        bus.cmd_rd      = rd;
        bus.cmd_rn      = rn;
        bus.cmd_rm      = rm;
        bus.cmd_imm     = imm;
        bus.cmd_last    = last;
    endtask

    task automatic begin_session();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Last command was just accepted: walk FLUSH -> DONE -> IDLE
    task automatic finish_session(input string tag);
        bus.cmd_valid = 1'b0;
        tick();
        check({tag, "_done"}, {31'h0, done}, 32'd1);
        check({tag, "_done_we"}, {31'h0, bus.imem_we}, 32'd0);
        tick();
        check({tag, "_idle_busy"}, {31'h0, busy}, 32'd0);
        check({tag, "_idle_done"}, {31'h0, done}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        cmd(3'd0, 2'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 24'd0, 1'b0);
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        check("rst_ready", {31'h0, bus.cmd_ready}, 32'd0);
        check("rst_we",    {31'h0, bus.imem_we}, 32'd0);
        check("rst_busy",  {31'h0, busy}, 32'd0);
        check("rst_done",  {31'h0, done}, 32'd0);
        check("rst_err",   {31'h0, err}, 32'd0);
        check("rst_addr",  {26'h0, bus.imem_addr}, 32'd0);
        check("rst_wdata", bus.imem_wdata, 32'd0);
        check("rst_count", {25'h0, count}, 32'd0);
        reset = 1'b0;
        tick();

        // ADD R1,R2,R3 AL
        begin_session();
        check("a_busy",  {31'h0, busy}, 32'd1);
        check("a_ready", {31'h0, bus.cmd_ready}, 32'd1);
        cmd(3'd0, 2'd0, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 24'd0, 1'b1);
        tick();
        check("a_we",    {31'h0, bus.imem_we}, 32'd1);
        check("a_wdata", bus.imem_wdata, 32'hE0821003);
        check("a_addr",  {26'h0, bus.imem_addr}, 32'd0);
        check("a_count", {25'h0, count}, 32'd1);
        check("a_flush_ready", {31'h0, bus.cmd_ready}, 32'd0);
        finish_session("a");

        // MOV R0,#5 ; CMP R0,#0 EQ back-to-back
        begin_session();
        cmd(3'd3, 2'd0, 1'b1, 1'b0, 4'd0, 4'd7, 4'd0, 24'd5, 1'b0);
        tick();
        check("b_mov_wdata", bus.imem_wdata, 32'hE3A00005);
        check("b_mov_addr",  {26'h0, bus.imem_addr}, 32'd0);
        cmd(3'd2, 2'd1, 1'b1, 1'b0, 4'd9, 4'd0, 4'd0, 24'd0, 1'b1);
        tick();
        check("b_cmp_we",    {31'h0, bus.imem_we}, 32'd1);
        check("b_cmp_wdata", bus.imem_wdata, 32'h03500000);
        check("b_cmp_addr",  {26'h0, bus.imem_addr}, 32'd1);
        check("b_count",     {25'h0, count}, 32'd2);
        finish_session("b");

        // LDR R2,[R0,#4] ; STR R2,[R0,R1]
        begin_session();
        cmd(3'd5, 2'd0, 1'b1, 1'b0, 4'd2, 4'd0, 4'd0, 24'd4, 1'b0);
        tick();
        check("c_ldr_wdata", bus.imem_wdata, 32'hE5902004);
        cmd(3'd4, 2'd0, 1'b0, 1'b0, 4'd2, 4'd0, 4'd1, 24'd0, 1'b1);
        tick();
        check("c_str_wdata", bus.imem_wdata, 32'hE7802001);
        check("c_str_addr",  {26'h0, bus.imem_addr}, 32'd1);
        finish_session("c");

        // B NE ; BL AL (last)
        begin_session();
        cmd(3'd6, 2'd2, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 24'h000002, 1'b0);
        tick();
        check("d_b_wdata", bus.imem_wdata, 32'h1A000002);
        cmd(3'd7, 2'd0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 24'hFFFFFE, 1'b1);
        tick();
        check("d_bl_wdata", bus.imem_wdata, 32'hEBFFFFFE);
        check("d_bl_done",  {31'h0, done}, 32'd0);
        check("d_bl_busy",  {31'h0, busy}, 32'd1);
        finish_session("d");

        // MOV R0,#300 is out of range for imm8
        begin_session();
        cmd(3'd3, 2'd0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 24'd300, 1'b1);
        tick();
        check("e_we",    {31'h0, bus.imem_we}, 32'd0);
        check("e_err",   {31'h0, err}, 32'd1);
        check("e_count", {25'h0, count}, 32'd0);
        finish_session("e");
        check("e_err_sticky", {31'h0, err}, 32'd1);

        // Start clears err; illegal cond, mem imm12 overflow, then DEPTH+1 commands
        begin_session();
        check("f_err_clr", {31'h0, err}, 32'd0);
        cmd(3'd0, 2'd3, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 24'd0, 1'b0);
        tick();
        check("f_cond_we",  {31'h0, bus.imem_we}, 32'd0);
        check("f_cond_err", {31'h0, err}, 32'd1);
        cmd(3'd5, 2'd0, 1'b1, 1'b0, 4'd1, 4'd2, 4'd0, 24'd4096, 1'b0);
        tick();
        check("f_mem_we",   {31'h0, bus.imem_we}, 32'd0);
        check("f_mem_cnt",  {25'h0, count}, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            cmd(3'd1, 2'd0, 1'b0, 1'b1, 4'd4, 4'd5, 4'd6, 24'd0, 1'b0);
            tick();
            check("f_fill_we",   {31'h0, bus.imem_we}, 32'd1);
            check("f_fill_addr", {26'h0, bus.imem_addr}, i);
        end
        check("f_sub_wdata", bus.imem_wdata, 32'hE0554006);
        cmd(3'd0, 2'd0, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 24'd0, 1'b1);
        tick();
        check("f_ovf_we",    {31'h0, bus.imem_we}, 32'd0);
        check("f_ovf_err",   {31'h0, err}, 32'd1);
        check("f_ovf_count", {25'h0, count}, DEPTH);
        check("f_ovf_addr",  {26'h0, bus.imem_addr}, DEPTH - 1);
        finish_session("f");

        // Reset in the middle of a stream aborts the session
        begin_session();
        cmd(3'd0, 2'd0, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 24'd0, 1'b0);
        tick();
        tick();
        check("g_pre_count", {25'h0, count}, 32'd2);
        reset = 1'b1;
        tick();
        check("g_rst_we",    {31'h0, bus.imem_we}, 32'd0);
        check("g_rst_busy",  {31'h0, busy}, 32'd0);
        check("g_rst_count", {25'h0, count}, 32'd0);
        check("g_rst_ready", {31'h0, bus.cmd_ready}, 32'd0);
        reset = 1'b0;
        bus.cmd_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
